// File: rtl/fetch_redirect_unit_if.sv
// rtl/fetch_redirect_unit_if.sv - EX-redirect / IF-ID bundle between the execute side and the fetch unit
// Purpose: groups the redirect request, stall, instruction-memory data and the
//          fetch/IF-ID outputs of fetch_redirect_unit.
// Ports  : slave  - fetch unit view (redirect/stall/instr in, fetch/IF-ID out)
//          master - environment view (drives redirect/stall/instr, observes outputs)
interface fetch_redirect_unit_if #(
   parameter int PC_W = 9
);
   logic            PcSel;
   logic [31:0]     BrPC;
   logic            Halt;
   logic            Stall;
   logic [31:0]     Instr_in;
   logic [PC_W-1:0] Fetch_Addr;
   logic [PC_W-1:0] IF_PC;
   logic [31:0]     IF_Instr;
   logic            IF_Valid;
   logic            Flush;
   logic            Halted;
   logic            Misalign;
   logic [15:0]     Redirect_Cnt;

   modport slave (
      input  PcSel, BrPC, Halt, Stall, Instr_in,
      output Fetch_Addr, IF_PC, IF_Instr, IF_Valid, Flush, Halted, Misalign, Redirect_Cnt
   );

   modport master (
      output PcSel, BrPC, Halt, Stall, Instr_in,
      input  Fetch_Addr, IF_PC, IF_Instr, IF_Valid, Flush, Halted, Misalign, Redirect_Cnt
   );
endinterface

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC register, IF/ID register and EX-redirect / halt control
// Purpose: owns the program counter and IF/ID pipeline register. Sequential
//          fetch advances by 4; an EX redirect replaces the PC and bubbles IF/ID;
//          a redirecting halt parks the unit in HALTED until reset.
// Ports  : clk   - single clock, rising edge
//          reset - asynchronous, active-low
//          bus   - fetch_redirect_unit_if.slave (redirect/stall/instr in,
//                  Fetch_Addr, IF/ID, Flush, Halted, Misalign, Redirect_Cnt out)
module fetch_redirect_unit #(
   parameter int PC_W = 9
) (
   input logic                   clk,
   input logic                   reset,
   fetch_redirect_unit_if.slave  bus
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;
   logic            if_valid_q, if_valid_d;
   logic            misalign_q, misalign_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            flush_c;

   // Target bits above the PC width are architecturally ignored.
   logic unused_brpc_hi;
   assign unused_brpc_hi = ^bus.BrPC[31:PC_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         pc_q       <= '0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         if_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      misalign_d = misalign_q;
      cnt_d      = cnt_q;
      flush_c    = 1'b0;

      case (state_q)
         RUN: begin
            if (bus.PcSel) begin
               // Redirect wins over Stall: the wrong-path fetch becomes a bubble.
               flush_c    = 1'b1;
               if_pc_d    = pc_q;
               if_instr_d = '0;
               if_valid_d = 1'b0;
               if (bus.BrPC[1:0] != 2'b00)
                  misalign_d = 1'b1;
               if (bus.Halt) begin
                  // Park on the halt's own address, unaligned bits kept as given.
                  pc_d    = bus.BrPC[PC_W-1:0];
                  state_d = HALTED;
               end else begin
                  pc_d = {bus.BrPC[PC_W-1:2], 2'b00};
                  if (cnt_q != 16'hFFFF)
                     cnt_d = cnt_q + 16'd1;
               end
            end else if (!bus.Stall) begin
               pc_d       = pc_q + PC_W'(4);
               if_pc_d    = pc_q;
               if_instr_d = bus.Instr_in;
               if_valid_d = 1'b1;
            end
         end
         HALTED: begin
            flush_c    = 1'b1;
            if_valid_d = 1'b0;
         end
         default: state_d = RUN;
      endcase
   end

   assign bus.Fetch_Addr   = pc_q;
   assign bus.IF_PC        = if_pc_q;
   assign bus.IF_Instr     = if_instr_q;
   assign bus.IF_Valid     = if_valid_q;
   assign bus.Flush        = flush_c & reset;
   assign bus.Halted       = (state_q == HALTED);
   assign bus.Misalign     = misalign_q;
   assign bus.Redirect_Cnt = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed table-driven bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

   localparam int PC_W = 9;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fetch_redirect_unit_if #(.PC_W(PC_W)) bus ();

   fetch_redirect_unit #(.PC_W(PC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pcsel;
      logic        halt;
      logic        stall;
      logic [31:0] brpc;
      logic [31:0] instr;
      logic        e_flush;
      logic [8:0]  e_fa;
      logic        chk_pc;
      logic [8:0]  e_ifpc;
      logic [31:0] e_instr;
      logic        e_valid;
      logic        e_halted;
      logic        e_mis;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic pcsel, logic halt, logic stall, logic [31:0] brpc,
                               logic [31:0] instr, logic e_flush, logic [8:0] e_fa,
                               logic chk_pc, logic [8:0] e_ifpc, logic [31:0] e_instr,
                               logic e_valid, logic e_halted, logic e_mis, logic [15:0] e_cnt);
      vec_t v;
      v.pcsel = pcsel; v.halt = halt; v.stall = stall; v.brpc = brpc; v.instr = instr;
      v.e_flush = e_flush; v.e_fa = e_fa; v.chk_pc = chk_pc; v.e_ifpc = e_ifpc;
      v.e_instr = e_instr; v.e_valid = e_valid; v.e_halted = e_halted; v.e_mis = e_mis;
      v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pcsel, input logic halt, input logic stall,
                        input logic [31:0] brpc, input logic [31:0] instr);
      bus.PcSel = pcsel; bus.Halt = halt; bus.Stall = stall;
      bus.BrPC = brpc; bus.Instr_in = instr;
   endtask

   task automatic chk_state(input string tag, input logic [8:0] fa, input logic cp,
                            input logic [8:0] ifpc, input logic [31:0] ins, input logic v,
                            input logic h, input logic m, input logic [15:0] c);
      chk({tag, ".fetch_addr"}, 32'(bus.Fetch_Addr), 32'(fa));
      if (cp) chk({tag, ".if_pc"}, 32'(bus.IF_PC), 32'(ifpc));
      chk({tag, ".if_instr"}, bus.IF_Instr, ins);
      chk({tag, ".if_valid"}, 32'(bus.IF_Valid), 32'(v));
      chk({tag, ".halted"}, 32'(bus.Halted), 32'(h));
      chk({tag, ".misalign"}, 32'(bus.Misalign), 32'(m));
      chk({tag, ".redirect_cnt"}, 32'(bus.Redirect_Cnt), 32'(c));
   endtask

   initial begin
      // Sequential fetch from reset, then a 3-cycle stall at PC=0x08.
      vecs.push_back(mk(0,0,0,0,32'hA000_0000, 0,9'h004, 1,9'h000,32'hA000_0000,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,32'hA000_0001, 0,9'h008, 1,9'h004,32'hA000_0001,1,0,0,0));
      vecs.push_back(mk(0,0,1,0,32'hDEAD_0001, 0,9'h008, 1,9'h004,32'hA000_0001,1,0,0,0));
      vecs.push_back(mk(0,0,1,0,32'hDEAD_0002, 0,9'h008, 1,9'h004,32'hA000_0001,1,0,0,0));
      vecs.push_back(mk(0,0,1,0,32'hDEAD_0003, 0,9'h008, 1,9'h004,32'hA000_0001,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,32'hA000_0002, 0,9'h00C, 1,9'h008,32'hA000_0002,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,32'hA000_0003, 0,9'h010, 1,9'h00C,32'hA000_0003,1,0,0,0));
      // Redirect at 0x10 to 0x40 while Stall is high: redirect wins.
      vecs.push_back(mk(1,0,1,32'h40,32'hBAD0_0000, 1,9'h040, 0,9'h000,32'h0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,32'hB000_0000, 0,9'h044, 1,9'h040,32'hB000_0000,1,0,0,1));
      // Back-to-back redirects; the second target has bits above PC_W that are dropped.
      vecs.push_back(mk(1,0,0,32'h100,32'hBAD0_0001, 1,9'h100, 0,9'h000,32'h0,0,0,0,2));
      vecs.push_back(mk(1,0,0,32'h280,32'hBAD0_0002, 1,9'h080, 0,9'h000,32'h0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,32'hB000_0001, 0,9'h084, 1,9'h080,32'hB000_0001,1,0,0,3));
      // Misaligned target aligned down, sticky flag, then wrap past 0x1FC.
      vecs.push_back(mk(1,0,0,32'h1FE,32'hBAD0_0003, 1,9'h1FC, 0,9'h000,32'h0,0,0,1,4));
      vecs.push_back(mk(0,0,0,0,32'hC000_0000, 0,9'h000, 1,9'h1FC,32'hC000_0000,1,0,1,4));
      // Halt without PcSel is ignored.
      vecs.push_back(mk(0,1,0,0,32'hC000_0001, 0,9'h004, 1,9'h000,32'hC000_0001,1,0,1,4));
      // Halt redirect to 0x24: counter unchanged, HALTED next edge.
      vecs.push_back(mk(1,1,0,32'h24,32'hBAD0_0004, 1,9'h024, 0,9'h000,32'h0,0,1,1,4));

      bus.PcSel = 1'b1; bus.Halt = 1'b0; bus.Stall = 1'b0;
      bus.BrPC = 32'h40; bus.Instr_in = 32'h1234_5678;
      reset = 1'b0;

      // Reset state, Flush suppressed even with PcSel high.
      #2;
      chk("rst.flush", 32'(bus.Flush), 32'h0);
      chk_state("rst", 9'h000, 1, 9'h000, 32'h0, 0, 0, 0, 16'h0);

      #10 reset = 1'b1;   // released between edges

      foreach (vecs[i]) begin
         drive(vecs[i].pcsel, vecs[i].halt, vecs[i].stall, vecs[i].brpc, vecs[i].instr);
         #1;
         chk($sformatf("v%0d.flush", i), 32'(bus.Flush), 32'(vecs[i].e_flush));
         @(posedge clk);
         #1;
         chk_state($sformatf("v%0d", i), vecs[i].e_fa, vecs[i].chk_pc, vecs[i].e_ifpc,
                   vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_mis,
                   vecs[i].e_cnt);
      end

      // HALTED ignores PcSel/Halt/Stall for 10 cycles.
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, k[0], k[1], 32'h80, 32'hEEEE_0000 + 32'(k));
         #1;
         chk($sformatf("h%0d.flush", k), 32'(bus.Flush), 32'h1);
         @(posedge clk);
         #1;
         chk_state($sformatf("h%0d", k), 9'h024, 0, 9'h000, 32'h0, 0, 1, 1, 16'd4);
      end

      // Asynchronous reset pulse while HALTED, between edges.
      #2 reset = 1'b0;
      #1;
      chk("arst.flush", 32'(bus.Flush), 32'h0);
      chk_state("arst", 9'h000, 1, 9'h000, 32'h0, 0, 0, 0, 16'h0);
      #1 reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hD000_0000);
      #1;
      chk("resume.flush", 32'(bus.Flush), 32'h0);
      @(posedge clk);
      #1;
      chk_state("resume0", 9'h004, 1, 9'h000, 32'hD000_0000, 1, 0, 0, 16'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hD000_0001);
      @(posedge clk);
      #1;
      chk_state("resume1", 9'h008, 1, 9'h004, 32'hD000_0001, 1, 0, 0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
